// File: rtl/mu0_mem_responder.sv
// Memory-side responder for the MU0 core: owns the unified program/data RAM,
// serves instruction and operand words after a programmable access latency.
module mu0_mem_responder #(
  parameter int    ADDR_W        = 12,
  parameter int    DATA_W        = 16,
  parameter int    LATENCY       = 1,
  parameter string RAM_INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] readdata,
  output logic              read_valid,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam int         DEPTH      = 2 ** ADDR_W;
  localparam logic [3:0] LAST_COUNT = 4'(LATENCY - 1);

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STO = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STP = 4'h7;

  typedef enum logic [1:0] {
    FETCH,
    OPERAND,
    VALID,
    HALT
  } state_t;

  state_t            state;
  logic [3:0]        count;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_word;
  logic [3:0]        fetched_op;
  logic [3:0]        held_op;
  logic              terminal;
  logic              ram_we;

  function automatic logic needs_operand(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

  // One read port shared by fetch and operand phases; the word must be
  // available on the terminal edge itself, so the read is asynchronous.
  assign rd_addr    = (state == FETCH) ? pc : instr[ADDR_W-1:0];
  assign rd_word    = mem[rd_addr];
  assign fetched_op = rd_word[DATA_W-1 -: 4];
  assign held_op    = instr[DATA_W-1 -: 4];
  assign terminal   = (count == LAST_COUNT);
  assign ram_we     = !rst && (state == VALID) && (held_op == OP_STO);

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[instr[ADDR_W-1:0]] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      count       <= '0;
      instr       <= '0;
      readdata    <= '0;
      read_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      read_valid <= 1'b0;
      unique case (state)
        FETCH: begin
          if (terminal) begin
            count <= '0;
            instr <= rd_word;
            if (needs_operand(fetched_op)) begin
              state <= OPERAND;
            end else begin
              state      <= VALID;
              read_valid <= 1'b1;
            end
          end else begin
            count <= count + 4'd1;
          end
        end
        OPERAND: begin
          if (terminal) begin
            count      <= '0;
            readdata   <= rd_word;
            state      <= VALID;
            read_valid <= 1'b1;
          end else begin
            count <= count + 4'd1;
          end
        end
        VALID: begin
          // The core executes on this edge; any STO commits here too.
          fetch_count <= fetch_count + 16'd1;
          if (held_op == OP_STP) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state <= FETCH;
          end
        end
        HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state <= FETCH;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mu0_mem_responder.sv
// Bench for mu0_mem_responder: an instruction-level MU0 model acts as the core
// and predicts every served instruction, operand, pulse spacing and count.
module tb_mu0_mem_responder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] pc;
  logic [15:0] writedata;
  logic [15:0] instr;
  logic [15:0] readdata;
  logic        read_valid;
  logic        halted;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [15:0] mm [4096];
  logic [11:0] m_pc;
  logic [15:0] m_acc;
  logic [15:0] m_rd;
  logic [15:0] m_count;
  bit          hs;

  always #5 clk = ~clk;

  mu0_mem_responder #(
    .ADDR_W(12),
    .DATA_W(16),
    .LATENCY(LAT),
    .RAM_INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .writedata(writedata),
    .instr(instr),
    .readdata(readdata),
    .read_valid(read_valid),
    .halted(halted),
    .fetch_count(fetch_count)
  );

  task automatic load(input logic [11:0] a, input logic [15:0] v);
    mm[a] = v;
    dut.mem[a] <= v;
  endtask

  task automatic model_reset();
    m_pc    = '0;
    m_acc   = '0;
    m_rd    = '0;
    m_count = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pc = '0;
    writedata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Acts as the core for up to max_instr instructions, checking each pulse.
  task automatic run(input int max_instr, input bit from_reset, output bit stopped);
    logic [15:0] ei;
    logic [15:0] erd;
    logic [3:0]  op;
    logic [11:0] a;
    bit          opnd;
    bit          first;
    int          exp_gap;
    int          gap;
    int          hi;
    stopped = 1'b0;
    first = from_reset;
    for (int n = 0; n < max_instr; n++) begin
      ei   = mm[m_pc];
      op   = ei[15:12];
      a    = ei[11:0];
      opnd = (op == 4'h0) || (op == 4'h2) || (op == 4'h3);
      erd  = opnd ? mm[a] : m_rd;
      exp_gap = LAT * (opnd ? 2 : 1) + (first ? 0 : 1);
      pc = m_pc;
      writedata = m_acc;
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!read_valid && gap < exp_gap + 8);
      checks++;
      if (!read_valid) begin
        $display("FAIL pulse_timeout: no read_valid after %0d cycles, required one after %0d (pc=%03h)",
                 gap, exp_gap, m_pc);
        errors++;
        stopped = 1'b1;
        return;
      end
      $display("[%0t] pc=%03h instr=%04h readdata=%04h count=%04h gap=%0d",
               $time, m_pc, instr, readdata, fetch_count, gap);
      checks++;
      if (gap != exp_gap) begin
        $display("FAIL pulse_gap: got %0d cycles, expected %0d (pc=%03h)", gap, exp_gap, m_pc);
        errors++;
      end
      checks++;
      if (instr !== ei) begin
        $display("FAIL instr: got %04h, expected %04h (pc=%03h)", instr, ei, m_pc);
        errors++;
      end
      checks++;
      if (readdata !== erd) begin
        $display("FAIL readdata: got %04h, expected %04h (pc=%03h)", readdata, erd, m_pc);
        errors++;
      end
      checks++;
      if (fetch_count !== m_count || halted !== 1'b0) begin
        $display("FAIL count_at_pulse: got count=%04h halted=%b, expected count=%04h halted=0",
                 fetch_count, halted, m_count);
        errors++;
      end
      case (op)
        4'h0: m_acc = erd;
        4'h1: mm[a] = m_acc;
        4'h2: m_acc = m_acc + erd;
        4'h3: m_acc = m_acc - erd;
        default: ;
      endcase
      m_rd = erd;
      m_count = m_count + 16'd1;
      if (op == 4'h4 || (op == 4'h5 && !m_acc[15]) || (op == 4'h6 && m_acc != 16'd0)) begin
        m_pc = a;
      end else begin
        m_pc = m_pc + 12'd1;
      end
      first = 1'b0;
      pc = m_pc;
      writedata = m_acc;
      if (op == 4'h7) begin
        @(negedge clk);
        checks++;
        if (halted !== 1'b1 || read_valid !== 1'b0 || fetch_count !== m_count) begin
          $display("FAIL stp_entry: got halted=%b valid=%b count=%04h, expected 1 0 %04h",
                   halted, read_valid, fetch_count, m_count);
          errors++;
        end
        hi = 0;
        repeat (20) begin
          @(negedge clk);
          if (read_valid !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0 || halted !== 1'b1 || fetch_count !== m_count) begin
          $display("FAIL halt_idle: got %0d pulses halted=%b count=%04h, expected 0 1 %04h",
                   hi, halted, fetch_count, m_count);
          errors++;
        end
        stopped = 1'b1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pc = '0;
    writedata = '0;
    for (int i = 0; i < 4096; i++) load(12'(i), 16'h0000);
    do_reset();
    checks++;
    if (instr !== 16'h0 || readdata !== 16'h0 || read_valid !== 1'b0 ||
        halted !== 1'b0 || fetch_count !== 16'h0) begin
      $display("FAIL reset_state: got instr=%h rd=%h valid=%b halted=%b count=%h, expected all zero",
               instr, readdata, read_valid, halted, fetch_count);
      errors++;
    end
  endtask

  task automatic test_lda();
    load(12'h000, 16'h0005);
    load(12'h001, 16'h7000);
    load(12'h005, 16'h1234);
    do_reset();
    run(5, 1'b1, hs);
  endtask

  task automatic test_jmp_stp();
    load(12'h000, 16'h4010);
    load(12'h010, 16'h7000);
    do_reset();
    run(5, 1'b1, hs);
    checks++;
    if (fetch_count !== 16'd2 || halted !== 1'b1) begin
      $display("FAIL jmp_stp_count: got count=%0d halted=%b, expected 2 1", fetch_count, halted);
      errors++;
    end
  endtask

  task automatic test_sto_lda();
    load(12'h000, 16'h0020);
    load(12'h001, 16'h1021);
    load(12'h002, 16'h0021);
    load(12'h003, 16'h7000);
    load(12'h020, 16'h00AA);
    load(12'h021, 16'h5555);
    do_reset();
    run(10, 1'b1, hs);
  endtask

  task automatic test_self_modify();
    load(12'h000, 16'h0010);
    load(12'h001, 16'h1003);
    load(12'h002, 16'h2011);
    load(12'h003, 16'h4000);
    load(12'h010, 16'h7000);
    load(12'h011, 16'h0000);
    do_reset();
    run(10, 1'b1, hs);
    checks++;
    if (halted !== 1'b1 || instr !== 16'h7000) begin
      $display("FAIL self_modify: got halted=%b instr=%04h, expected 1 7000", halted, instr);
      errors++;
    end
  endtask

  task automatic test_reset_operand();
    load(12'h000, 16'h0021);
    load(12'h001, 16'h0022);
    load(12'h002, 16'h7000);
    load(12'h022, 16'h0F0F);
    do_reset();
    run(1, 1'b1, hs);
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if (instr !== 16'h0022 || fetch_count !== 16'd1 || read_valid !== 1'b0) begin
      $display("FAIL pre_reset_operand: got instr=%04h count=%0d valid=%b, expected 0022 1 0",
               instr, fetch_count, read_valid);
      errors++;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (instr !== 16'h0 || readdata !== 16'h0 || read_valid !== 1'b0 ||
        halted !== 1'b0 || fetch_count !== 16'h0) begin
      $display("FAIL reset_in_operand: got instr=%h rd=%h valid=%b halted=%b count=%h, expected all zero",
               instr, readdata, read_valid, halted, fetch_count);
      errors++;
    end
    rst = 1'b0;
    model_reset();
    pc = '0;
    writedata = '0;
    run(10, 1'b1, hs);
  endtask

  task automatic test_count_wrap();
    load(12'h000, 16'h4000);
    do_reset();
    run(2, 1'b1, hs);
    dut.fetch_count <= 16'hFFF0;
    m_count = 16'hFFF1;
    run(32, 1'b0, hs);
    checks++;
    if (hs) begin
      $display("FAIL wrap_run: got early stop, expected 32 JMP instructions");
      errors++;
    end
  endtask

  task automatic test_random();
    int          r;
    logic [3:0]  op;
    logic [11:0] a;
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 32; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < 80) op = 4'($urandom_range(0, 6));
        else if (r < 88) op = 4'h7;
        else op = 4'($urandom_range(8, 15));
        if (op >= 4'h4 && op <= 4'h6) a = 12'($urandom_range(0, 31));
        else if ($urandom_range(0, 9) == 0) a = 12'hFFF;
        else a = 12'h040 + 12'($urandom_range(0, 31));
        load(12'(i), {op, a});
      end
      for (int i = 0; i < 32; i++) load(12'h040 + 12'(i), 16'($urandom));
      load(12'hFFF, 16'($urandom));
      do_reset();
      run(40, 1'b1, hs);
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_jmp_stp();
    test_sto_lda();
    test_self_modify();
    test_reset_operand();
    test_count_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
